seg_scan: RTL

Multiplexed multi-digit seven-segment display driver: the parametrised successor to our single-digit BCD decoder. Holds a DIGITS-wide packed BCD/hex value plus decimal points, scans the digits at a prescaled rate, and drives one shared segment bus with one-hot digit enables. It sits between the counter/datapath logic and the board's display pins. Values are double-buffered and applied only at frame boundaries, so the display never tears.

---
 rtl/seg_scan.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - multiplexed multi-digit seven-segment scanner with frame-synchronous value update
// Optional leading-zero blanking: define SEG_SCAN_LZB_EN.
module seg_scan #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int ANODE    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  hex,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  output logic [6:0]            segment,
  output logic                  dpout,
  output logic [DIGITS-1:0]     digit,
  output logic                  pending,
  output logic                  frame
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic          POL      = (ANODE != 0);

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   staged_bcd_q, staged_bcd_d;
  logic [DIGITS-1:0]     staged_dp_q, staged_dp_d;
  logic [4*DIGITS-1:0]   shadow_bcd_q, shadow_bcd_d;
  logic [DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
  logic                  pending_q, pending_d;
  logic                  frame_q, frame_d;
  logic [6:0]            segment_q, segment_d;
  logic                  dpout_q, dpout_d;
  logic [DIGITS-1:0]     digit_q, digit_d;

  logic                  slot_end;
  logic                  wrap;
  logic [3:0]            code;
  logic [6:0]            seg_act;
  logic                  dp_act;
  logic [DIGITS-1:0]     digit_act;

  function automatic logic [6:0] glyph(input logic [3:0] c, input logic hex_en);
    logic [6:0] g;
    case (c)
      4'h0: g = 7'b0111111;
      4'h1: g = 7'b0000110;
      4'h2: g = 7'b1011011;
      4'h3: g = 7'b1001111;
      4'h4: g = 7'b1100110;
      4'h5: g = 7'b1101101;
      4'h6: g = 7'b1111101;
      4'h7: g = 7'b0000111;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1101111;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b1111100;
      4'hC: g = 7'b0111001;
      4'hD: g = 7'b1011110;
      4'hE: g = 7'b1111001;
      default: g = 7'b1110001;
    endcase
    if (!hex_en && c > 4'h9) g = 7'b0000000;
    return g;
  endfunction

`ifdef SEG_SCAN_LZB_EN
  // A non-zero position is blank when it and every more significant code are zero.
  function automatic logic lz_blank(input logic [4*DIGITS-1:0] codes, input logic [IW-1:0] pos);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (i >= int'(pos) && codes[4*i +: 4] != 4'h0) upper_zero = 1'b0;
    end
    return (pos != '0) && upper_zero;
  endfunction
`endif

  always_comb begin
    presc_d      = presc_q;
    idx_d        = idx_q;
    staged_bcd_d = staged_bcd_q;
    staged_dp_d  = staged_dp_q;
    shadow_bcd_d = shadow_bcd_q;
    shadow_dp_d  = shadow_dp_q;
    pending_d    = pending_q;
    slot_end     = en && (presc_q == PRE_LAST);
    wrap         = slot_end && (idx_q == IDX_LAST);
    frame_d      = wrap;

    if (slot_end) begin
      presc_d = '0;
      idx_d   = wrap ? '0 : idx_q + 1'b1;
    end else if (en) begin
      presc_d = presc_q + 1'b1;
    end

    if (load) begin
      staged_bcd_d = bcd;
      staged_dp_d  = dp;
      pending_d    = 1'b1;
    end

    // A load coinciding with the boundary bypasses staging so it shows this frame.
    if (wrap && (pending_q || load)) begin
      shadow_bcd_d = load ? bcd : staged_bcd_q;
      shadow_dp_d  = load ? dp  : staged_dp_q;
      pending_d    = 1'b0;
    end

    code      = shadow_bcd_d[{idx_d, 2'b00} +: 4];
    seg_act   = glyph(code, hex);
`ifdef SEG_SCAN_LZB_EN
    if (lz_blank(shadow_bcd_d, idx_d)) seg_act = 7'b0000000;
`endif
    dp_act    = shadow_dp_d[idx_d];
    digit_act = DIGITS'(1) << idx_d;
    if (!en) begin
      seg_act   = 7'b0000000;
      dp_act    = 1'b0;
      digit_act = '0;
    end

    segment_d = seg_act ^ {7{POL}};
    dpout_d   = dp_act ^ POL;
    digit_d   = digit_act ^ {DIGITS{POL}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      staged_bcd_q <= '0;
      staged_dp_q  <= '0;
      shadow_bcd_q <= '0;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      frame_q      <= 1'b0;
      segment_q    <= {7{POL}};
      dpout_q      <= POL;
      digit_q      <= {DIGITS{POL}};
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      staged_bcd_q <= staged_bcd_d;
      staged_dp_q  <= staged_dp_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      frame_q      <= frame_d;
      segment_q    <= segment_d;
      dpout_q      <= dpout_d;
      digit_q      <= digit_d;
    end
  end

  assign segment = segment_q;
  assign dpout   = dpout_q;
  assign digit   = digit_q;
  assign pending = pending_q;
  assign frame   = frame_q;

endmodule
